// File: rtl/bcd_countdown_timer.sv
// mm:ss:cc BCD countdown timer advanced by a 10 ms tick; raises a one-cycle
// done pulse and a sticky expired flag on reaching 00:00:00.
module bcd_countdown_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic [3:0] set_min1_i,
  input  logic [3:0] set_min0_i,
  input  logic [3:0] set_sec1_i,
  input  logic [3:0] set_sec0_i,
  output logic [3:0] min1_o,
  output logic [3:0] min0_o,
  output logic [3:0] sec1_o,
  output logic [3:0] sec0_o,
  output logic [3:0] cs1_o,
  output logic [3:0] cs0_o,
  output logic       running_o,
  output logic       done_o,
  output logic       expired_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e     state_q;
  logic [3:0] min1_q, min0_q, sec1_q, sec0_q, cs1_q, cs0_q;
  logic [3:0] min1_d, min0_d, sec1_d, sec0_d, cs1_d, cs0_d;
  logic       b_cs0, b_cs1, b_sec0, b_sec1, b_min0;
  logic       running_q, done_q, expired_q;
  logic       dec_zero, cur_nonzero;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Ripple-borrow decrement of the whole value by one centisecond.
  always_comb begin
    b_cs0  = (cs0_q == 4'd0);
    cs0_d  = b_cs0 ? 4'd9 : cs0_q - 4'd1;
    b_cs1  = b_cs0 && (cs1_q == 4'd0);
    cs1_d  = b_cs0 ? ((cs1_q == 4'd0) ? 4'd9 : cs1_q - 4'd1) : cs1_q;
    b_sec0 = b_cs1 && (sec0_q == 4'd0);
    sec0_d = b_cs1 ? ((sec0_q == 4'd0) ? 4'd9 : sec0_q - 4'd1) : sec0_q;
    b_sec1 = b_sec0 && (sec1_q == 4'd0);
    sec1_d = b_sec0 ? ((sec1_q == 4'd0) ? 4'd5 : sec1_q - 4'd1) : sec1_q;
    b_min0 = b_sec1 && (min0_q == 4'd0);
    min0_d = b_sec1 ? ((min0_q == 4'd0) ? 4'd9 : min0_q - 4'd1) : min0_q;
    min1_d = b_min0 ? ((min1_q == 4'd0) ? 4'd5 : min1_q - 4'd1) : min1_q;
  end

  assign dec_zero    = ({min1_d, min0_d, sec1_d, sec0_d, cs1_d, cs0_d} == 24'd0);
  assign cur_nonzero = ({min1_q, min0_q, sec1_q, sec0_q, cs1_q, cs0_q} != 24'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      min1_q    <= 4'd0;
      min0_q    <= 4'd0;
      sec1_q    <= 4'd0;
      sec0_q    <= 4'd0;
      cs1_q     <= 4'd0;
      cs0_q     <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        state_q   <= S_IDLE;
        min1_q    <= clamp(set_min1_i, 4'd5);
        min0_q    <= clamp(set_min0_i, 4'd9);
        sec1_q    <= clamp(set_sec1_i, 4'd5);
        sec0_q    <= clamp(set_sec0_i, 4'd9);
        cs1_q     <= 4'd0;
        cs0_q     <= 4'd0;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!pause_i && start_i && cur_nonzero) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (pause_i) begin
              state_q   <= S_PAUSED;
              running_q <= 1'b0;
            end else if (tick_i) begin
              min1_q <= min1_d;
              min0_q <= min0_d;
              sec1_q <= sec1_d;
              sec0_q <= sec0_d;
              cs1_q  <= cs1_d;
              cs0_q  <= cs0_d;
              if (dec_zero) begin
                state_q   <= S_EXPIRED;
                running_q <= 1'b0;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end
            end
          end
          S_PAUSED: begin
            if (!pause_i && start_i) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign min1_o    = min1_q;
  assign min0_o    = min0_q;
  assign sec1_o    = sec1_q;
  assign sec0_o    = sec0_q;
  assign cs1_o     = cs1_q;
  assign cs0_o     = cs0_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign expired_o = expired_q;

endmodule
